// File: rtl/ddr4_act_scheduler.sv
// DDR4 ACT/PRE command-issue stage: enforces tRRD_S/L, tFAW, tRAS and tRP per rank/bank
// and drives a fully registered command bus, tracking which banks are open.
module ddr4_act_scheduler #(
   parameter int RANKS     = 1,
   parameter int BGWIDTH   = 2,
   parameter int BAWIDTH   = 2,
   parameter int ADDRWIDTH = 17,
   parameter int TRRD_S    = 4,
   parameter int TRRD_L    = 6,
   parameter int TFAW      = 20,
   parameter int TRAS      = 12,
   parameter int TRP       = 8
) (
   input  logic                                      ck_t,
   input  logic                                      reset,
   input  logic                                      req_valid,
   output logic                                      req_ready,
   input  logic                                      req_pre,
   input  logic [((RANKS > 1) ? $clog2(RANKS) : 1)-1:0] req_rank,
   input  logic [BGWIDTH-1:0]                        req_bg,
   input  logic [BAWIDTH-1:0]                        req_ba,
   input  logic [ADDRWIDTH-1:0]                      req_row,
   output logic [RANKS-1:0]                          cs_n,
   output logic                                      act_n,
   output logic [BGWIDTH-1:0]                        bg,
   output logic [BAWIDTH-1:0]                        ba,
   output logic [ADDRWIDTH-1:0]                      A,
   output logic [RANKS*(2**(BGWIDTH+BAWIDTH))-1:0]   open_banks,
   output logic                                      err
);

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int NB      = 2 ** (BGWIDTH + BAWIDTH);
   localparam int NBT     = RANKS * NB;
   localparam int RRD_MAX = imax(TRRD_S, TRRD_L);
   localparam int TMAX    = imax(imax(RRD_MAX, TFAW), imax(TRAS, TRP));
   localparam int CW      = $clog2(TMAX + 1);
   localparam logic [ADDRWIDTH-1:0] PRE_ADDR = ADDRWIDTH'(32'h0000_8000);

   // Bank timers count down to zero; rrd_el counts cycles since the rank's last ACT acceptance.
   logic [CW-1:0]      ras_cnt [NBT];
   logic [CW-1:0]      rp_cnt  [NBT];
   logic [CW-1:0]      faw_cnt [RANKS][4];
   logic [CW-1:0]      rrd_el  [RANKS];
   logic [BGWIDTH-1:0] last_bg [RANKS];

   int   r;
   int   idx;
   int   faw_slot;
   logic bank_open;
   logic rrd_ok;
   logic faw_ok;

   // Handshake: a request transfers on any rising edge where req_valid && req_ready; req_ready
   // is derived from the request fields and timers only, never from req_valid.
   always_comb begin
      r         = 0;
      idx       = 0;
      faw_slot  = 0;
      faw_ok    = 1'b0;
      rrd_ok    = 1'b0;
      bank_open = 1'b0;
      req_ready = 1'b0;
      if (int'(req_rank) < RANKS) r = int'(req_rank);
      idx       = r * NB + int'({req_bg, req_ba});
      bank_open = open_banks[idx];
      if (req_bg == last_bg[r]) rrd_ok = (int'(rrd_el[r]) >= TRRD_L);
      else                      rrd_ok = (int'(rrd_el[r]) >= TRRD_S);
      for (int s = 3; s >= 0; s--) begin
         if (faw_cnt[r][s] == '0) begin
            faw_ok   = 1'b1;
            faw_slot = s;
         end
      end
      if (reset)          req_ready = 1'b0;
      else if (req_pre)   req_ready = (ras_cnt[idx] == '0);
      else if (bank_open) req_ready = 1'b1;
      else                req_ready = rrd_ok && faw_ok && (rp_cnt[idx] == '0);
   end

   always_ff @(posedge ck_t) begin
      if (reset) begin
         cs_n       <= '1;
         act_n      <= 1'b1;
         bg         <= '0;
         ba         <= '0;
         A          <= '0;
         err        <= 1'b0;
         open_banks <= '0;
         for (int i = 0; i < NBT; i++) begin
            ras_cnt[i] <= '0;
            rp_cnt[i]  <= '0;
         end
         for (int k = 0; k < RANKS; k++) begin
            rrd_el[k]  <= CW'(RRD_MAX);
            last_bg[k] <= '0;
            for (int s = 0; s < 4; s++) faw_cnt[k][s] <= '0;
         end
      end else begin
         cs_n  <= '1;
         act_n <= 1'b1;
         bg    <= '0;
         ba    <= '0;
         A     <= '0;
         err   <= 1'b0;
         for (int i = 0; i < NBT; i++) begin
            if (ras_cnt[i] != '0) ras_cnt[i] <= ras_cnt[i] - 1'b1;
            if (rp_cnt[i]  != '0) rp_cnt[i]  <= rp_cnt[i] - 1'b1;
         end
         for (int k = 0; k < RANKS; k++) begin
            if (int'(rrd_el[k]) < RRD_MAX) rrd_el[k] <= rrd_el[k] + 1'b1;
            for (int s = 0; s < 4; s++) begin
               if (faw_cnt[k][s] != '0) faw_cnt[k][s] <= faw_cnt[k][s] - 1'b1;
            end
         end
         if (req_valid && req_ready) begin
            if (req_pre) begin
               cs_n[r]         <= 1'b0;
               bg              <= req_bg;
               ba              <= req_ba;
               A               <= PRE_ADDR;
               open_banks[idx] <= 1'b0;
               rp_cnt[idx]     <= CW'(TRP - 1);
            end else if (bank_open) begin
               err <= 1'b1;
            end else begin
               // Timers load with T-1 so they reach zero exactly when the next command may be accepted.
               cs_n[r]             <= 1'b0;
               act_n               <= 1'b0;
               bg                  <= req_bg;
               ba                  <= req_ba;
               A                   <= req_row;
               open_banks[idx]     <= 1'b1;
               ras_cnt[idx]        <= CW'(TRAS - 1);
               rrd_el[r]           <= CW'(1);
               last_bg[r]          <= req_bg;
               faw_cnt[r][faw_slot] <= CW'(TFAW - 1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ddr4_act_scheduler.sv
// Bench for ddr4_act_scheduler: a timing-rule reference model predicts each command's bus cycle
// and contents; a negedge monitor pops and compares whatever the DUT puts on the bus.
module tb_ddr4_act_scheduler;

   localparam int TRRD_S = 4;
   localparam int TRRD_L = 6;
   localparam int TFAW   = 20;
   localparam int TRAS   = 12;
   localparam int TRP    = 8;
   localparam int NB     = 16;
   localparam int BW     = 40;
   localparam int W      = 32 + BW;
   localparam logic [BW-17:0] DES = {1'b1, 1'b1, 2'b00, 2'b00, 17'd0, 1'b0};

   logic        ck_t = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_pre = 1'b0;
   logic [0:0]  req_rank = 1'b0;
   logic [1:0]  req_bg = 2'd0;
   logic [1:0]  req_ba = 2'd0;
   logic [16:0] req_row = 17'd0;
   logic [0:0]  cs_n;
   logic        act_n;
   logic [1:0]  bg;
   logic [1:0]  ba;
   logic [16:0] A;
   logic [15:0] open_banks;
   logic        err;

   ddr4_act_scheduler #(
      .RANKS(1), .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17),
      .TRRD_S(TRRD_S), .TRRD_L(TRRD_L), .TFAW(TFAW), .TRAS(TRAS), .TRP(TRP)
   ) dut (
      .ck_t(ck_t), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_pre(req_pre), .req_rank(req_rank), .req_bg(req_bg), .req_ba(req_ba),
      .req_row(req_row), .cs_n(cs_n), .act_n(act_n), .bg(bg), .ba(ba), .A(A),
      .open_banks(open_banks), .err(err)
   );

   // clock / cycle counter
   always #5 ck_t = ~ck_t;
   int cyc = 0;
   always @(posedge ck_t) cyc <= cyc + 1;

   int          checks = 0;
   int          failures = 0;
   logic [W-1:0] exp_q[$];
   int          obs_q[$];
   bit          mon_en = 1'b0;
   int          rel_tab[8];

   // reference model: absolute bus cycles of past commands
   int          act_hist[$];
   int          last_act_bus;
   int          last_bg_m;
   int          bank_act[NB];
   int          bank_pre[NB];
   logic [15:0] m_open;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [BW-1:0] pack_bus(input logic cs, input logic an, input logic [1:0] g,
                                              input logic [1:0] b, input logic [16:0] a,
                                              input logic e, input logic [15:0] o);
      return {cs, an, g, b, a, e, o};
   endfunction

   function automatic void model_reset();
      act_hist.delete();
      last_act_bus = -1000;
      last_bg_m    = -1;
      for (int i = 0; i < NB; i++) begin
         bank_act[i] = -1000;
         bank_pre[i] = -1000;
      end
      m_open = 16'd0;
   endfunction

   function automatic void model_push(input bit pre, input int g, input int b,
                                      input logic [16:0] row, input int t0);
      int k;
      int t;
      logic [BW-1:0] bus;
      k = g * 4 + b;
      if (!pre && m_open[k]) begin
         t   = t0 + 1;
         bus = pack_bus(1'b1, 1'b1, 2'd0, 2'd0, 17'd0, 1'b1, m_open);
      end else if (pre) begin
         t           = imax(t0 + 1, bank_act[k] + TRAS);
         bank_pre[k] = t;
         m_open[k]   = 1'b0;
         bus = pack_bus(1'b0, 1'b1, 2'(g), 2'(b), 17'h08000, 1'b0, m_open);
      end else begin
         t = imax(t0 + 1, last_act_bus + ((g == last_bg_m) ? TRRD_L : TRRD_S));
         if (act_hist.size() >= 4) t = imax(t, act_hist[act_hist.size() - 4] + TFAW);
         t = imax(t, bank_pre[k] + TRP);
         act_hist.push_back(t);
         last_act_bus = t;
         last_bg_m    = g;
         bank_act[k]  = t;
         m_open[k]    = 1'b1;
         bus = pack_bus(1'b0, 1'b0, 2'(g), 2'(b), row, 1'b0, m_open);
      end
      exp_q.push_back({32'(t), bus});
   endfunction

   // driver tasks (called just after a rising edge)
   task automatic send(input bit pre, input int g, input int b, input logic [16:0] row);
      bit done;
      model_push(pre, g, b, row, cyc);
      req_valid = 1'b1;
      req_pre   = pre;
      req_bg    = 2'(g);
      req_ba    = 2'(b);
      req_row   = row;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge ck_t);
         if (req_ready) done = 1'b1;
         @(posedge ck_t);
         #1;
      end
      req_valid = 1'b0;
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL handshake_timeout: req_ready=0 for 100 cycles, required 1 (pre=%0d bg=%0d ba=%0d)",
                  pre, g, b);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = 1'b1;
      req_pre   = 1'b0;
      req_bg    = 2'($urandom_range(0, 3));
      req_ba    = 2'($urandom_range(0, 3));
      req_row   = 17'($urandom);
      for (int i = 0; i < 2; i++) begin
         @(negedge ck_t);
         checks++;
         if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_in_reset: req_ready=%b, required 0", req_ready);
         end
         if (i == 1) begin
            checks++;
            if (open_banks !== 16'd0 || err !== 1'b0) begin
               failures++;
               $display("FAIL reset_state: open_banks=%h err=%b, required 0000 0", open_banks, err);
            end
         end
         @(posedge ck_t);
         #1;
      end
      reset     = 1'b0;
      req_valid = 1'b0;
      model_reset();
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge ck_t);
      checks++;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain_timeout: %0d expected commands never appeared, required 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge ck_t);
      #1;
   endtask

   task automatic expect_rel(input string name, input int base, input int n);
      checks++;
      if (obs_q.size() != n) begin
         failures++;
         $display("FAIL %s_count: %0d bus commands, required %0d", name, obs_q.size(), n);
      end
      for (int i = 0; i < n && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] - base != rel_tab[i]) begin
            failures++;
            $display("FAIL %s_cycle%0d: bus command at cycle %0d, required %0d", name, i,
                     obs_q[i] - base, rel_tab[i]);
         end
      end
   endtask

   // scoreboard monitor
   always @(negedge ck_t) begin
      logic [W-1:0]  e;
      logic [BW-1:0] got;
      if (mon_en) begin
         got = pack_bus(cs_n[0], act_n, bg, ba, A, err, open_banks);
         while (exp_q.size() > 0 && int'(exp_q[0][W-1:BW]) < cyc) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_cmd: nothing at cycle %0d, required bus %h", int'(e[W-1:BW]), e[BW-1:0]);
         end
         checks++;
         if (exp_q.size() > 0 && int'(exp_q[0][W-1:BW]) == cyc) begin
            e = exp_q.pop_front();
            if (got !== e[BW-1:0]) begin
               failures++;
               $display("FAIL bus_cmd at cycle %0d: got %h, required %h", cyc, got, e[BW-1:0]);
            end
         end else if (got[BW-1:16] !== DES) begin
            failures++;
            $display("FAIL unexpected_cmd at cycle %0d: got %h, required DES %h", cyc, got[BW-1:16], DES);
         end
         if (cs_n[0] === 1'b0) obs_q.push_back(cyc);
      end
   end

   initial begin
      int base;
      model_reset();
      repeat (3) @(posedge ck_t);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      // four-bank-group stream, fifth ACT held off by tFAW
      do_reset();
      obs_q.delete();
      base = cyc;
      send(1'b0, 0, 0, 17'd1);
      send(1'b0, 1, 0, 17'($urandom));
      send(1'b0, 2, 0, 17'($urandom));
      send(1'b0, 3, 0, 17'($urandom));
      send(1'b0, 0, 1, 17'($urandom));
      drain();
      rel_tab = '{1, 5, 9, 13, 21, 0, 0, 0};
      expect_rel("tfaw_stream", base, 5);

      // same bank group: tRRD_L
      do_reset();
      obs_q.delete();
      base = cyc;
      send(1'b0, 0, 0, 17'h1abcd);
      send(1'b0, 0, 1, 17'h00042);
      drain();
      rel_tab = '{1, 7, 0, 0, 0, 0, 0, 0};
      expect_rel("trrd_l", base, 2);

      // ACT, PRE (tRAS), re-ACT (tRP)
      do_reset();
      obs_q.delete();
      base = cyc;
      send(1'b0, 0, 0, 17'h00077);
      send(1'b1, 0, 0, 17'h1ffff);
      send(1'b0, 0, 0, 17'h00123);
      drain();
      rel_tab = '{1, 13, 21, 0, 0, 0, 0, 0};
      expect_rel("tras_trp", base, 3);

      // ACT to an open bank: consumed, err pulse, no bus command
      do_reset();
      obs_q.delete();
      base = cyc;
      send(1'b0, 1, 2, 17'h00005);
      send(1'b0, 1, 2, 17'h00009);
      drain();
      rel_tab = '{1, 0, 0, 0, 0, 0, 0, 0};
      expect_rel("open_bank_err", base, 1);

      // reset between accepted ACTs, then an immediate ACT
      do_reset();
      send(1'b0, 2, 3, 17'h00011);
      send(1'b0, 3, 3, 17'h00022);
      do_reset();
      obs_q.delete();
      base = cyc;
      send(1'b0, 3, 3, 17'h00033);
      drain();
      rel_tab = '{1, 0, 0, 0, 0, 0, 0, 0};
      expect_rel("post_reset", base, 1);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge ck_t);
            #1;
         end
         send(($urandom_range(0, 9) < 4), $urandom_range(0, 3), $urandom_range(0, 3), 17'($urandom));
         if ($urandom_range(0, 49) == 0) do_reset();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
